// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key presses into click / double-click / long-press events.
// Define KEY_DCLICK_EN to build the double-click path (WAIT2/PRESS2); otherwise a release emits a click at once.
//
// state     | meaning
// IDLE      | key released, waiting for a press
// PRESS1    | first press held, counting toward a long press
// LONG_HELD | long press reported, waiting for release
// WAIT2     | first release seen, counting the gap for a second press
// PRESS2    | second press held, double-click reported on release
module key_event_decoder #(
    parameter logic [31:0] LONG_CYCLES   = 32'd50000000,
    parameter logic [31:0] DCLICK_CYCLES = 32'd15000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    input  logic       ev_ready,
    output logic       ev_ovf
);

    localparam logic [1:0] CODE_CLICK  = 2'b01;
    localparam logic [1:0] CODE_LONG   = 2'b11;
    // The IDLE sample is the first high sample, so PRESS1 reaches LONG_CYCLES samples at cnt = LONG_CYCLES-2.
    localparam logic [31:0] LONG_TC    = LONG_CYCLES - 32'd2;

`ifdef KEY_DCLICK_EN
    localparam logic [1:0] CODE_DOUBLE = 2'b10;
    localparam logic [31:0] DCLICK_TC  = DCLICK_CYCLES - 32'd1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd2,
        WAIT2     = 3'd3,
        PRESS2    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS1    = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    logic unused_dclick;
    assign unused_dclick = ^DCLICK_CYCLES;
`endif

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ev_valid_q, ev_valid_d;
    logic [1:0]  ev_code_q, ev_code_d;
    logic        ev_ovf_q, ev_ovf_d;

    logic        emit;
    logic [1:0]  emit_code;
    logic        accept;
    logic        counting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 32'd0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= 2'b00;
            ev_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_ovf_q   <= ev_ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        counting = 1'b0;
        case (state_q)
            IDLE: begin
                if (key) state_d = PRESS1;
            end
            PRESS1: begin
                counting = 1'b1;
                if (!key) begin
`ifdef KEY_DCLICK_EN
                    state_d = WAIT2;
`else
                    state_d = IDLE;
`endif
                end else if (cnt_q == LONG_TC) begin
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (!key) state_d = IDLE;
            end
`ifdef KEY_DCLICK_EN
            WAIT2: begin
                counting = 1'b1;
                // A rising key on the terminal cycle still counts as the second press.
                if (key) begin
                    state_d = PRESS2;
                end else if (cnt_q == DCLICK_TC) begin
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                if (!key) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = 32'd0;
        end else if (counting) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_code = CODE_CLICK;
        case (state_q)
            PRESS1: begin
                if (key && (cnt_q == LONG_TC)) begin
                    emit      = 1'b1;
                    emit_code = CODE_LONG;
                end
`ifndef KEY_DCLICK_EN
                if (!key) begin
                    emit      = 1'b1;
                    emit_code = CODE_CLICK;
                end
`endif
            end
`ifdef KEY_DCLICK_EN
            WAIT2: begin
                if (!key && (cnt_q == DCLICK_TC)) begin
                    emit      = 1'b1;
                    emit_code = CODE_CLICK;
                end
            end
            PRESS2: begin
                if (!key) begin
                    emit      = 1'b1;
                    emit_code = CODE_DOUBLE;
                end
            end
`endif
            default: begin
                emit      = 1'b0;
                emit_code = CODE_CLICK;
            end
        endcase

        // Single event slot: a new event only lands if the slot is empty or being drained this cycle.
        accept     = ev_valid_q && ev_ready;
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        ev_ovf_d   = ev_ovf_q;
        if (emit) begin
            if (!ev_valid_q || accept) begin
                ev_valid_d = 1'b1;
                ev_code_d  = emit_code;
            end else begin
                ev_ovf_d   = 1'b1;
            end
        end else if (accept) begin
            ev_valid_d = 1'b0;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_code  = ev_code_q;
    assign ev_ovf   = ev_ovf_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Testbench for key_event_decoder: directed scenarios plus random key/ready traffic,
// checked by a press-level reference model feeding an event scoreboard.
module tb_key_event_decoder;

    localparam int LONG   = 100;
    localparam int DCLICK = 40;

    logic       clk;
    logic       rst;
    logic       key;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_ready;
    logic       ev_ovf;

    key_event_decoder #(
        .LONG_CYCLES   (32'd100),
        .DCLICK_CYCLES (32'd40)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_ready (ev_ready),
        .ev_ovf   (ev_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    // Press-level reference model: tracks run lengths of the key level.
    int   cyc        = 0;
    logic last_rst   = 1'b0;
    logic m_in_press = 1'b0;
    logic m_waiting  = 1'b0;
    logic m_second   = 1'b0;
    logic m_long     = 1'b0;
    int   m_hi_run   = 0;
    int   m_lo_run   = 0;
    logic m_valid    = 1'b0;
    logic m_ovf      = 1'b0;

    always @(posedge clk) begin
        logic       emit;
        logic [1:0] code;
        logic       hs;
        cyc++;
        last_rst = rst;
        if (rst) begin
            m_in_press = 1'b0;
            m_waiting  = 1'b0;
            m_second   = 1'b0;
            m_long     = 1'b0;
            m_hi_run   = 0;
            m_lo_run   = 0;
            m_valid    = 1'b0;
            m_ovf      = 1'b0;
            exp_q.delete();
        end else begin
            emit = 1'b0;
            code = 2'b00;
            if (key) begin
                if (m_waiting) begin
                    m_waiting  = 1'b0;
                    m_in_press = 1'b1;
                    m_second   = 1'b1;
                end else if (m_in_press) begin
                    m_hi_run++;
                    if (!m_second && !m_long && m_hi_run == LONG) begin
                        emit   = 1'b1;
                        code   = 2'b11;
                        m_long = 1'b1;
                    end
                end else begin
                    m_in_press = 1'b1;
                    m_hi_run   = 1;
                    m_second   = 1'b0;
                    m_long     = 1'b0;
                end
            end else begin
                if (m_in_press) begin
                    m_in_press = 1'b0;
                    if (!m_long) begin
                        if (m_second) begin
                            emit = 1'b1;
                            code = 2'b10;
                        end else begin
`ifdef KEY_DCLICK_EN
                            m_waiting = 1'b1;
                            m_lo_run  = 1;
`else
                            emit = 1'b1;
                            code = 2'b01;
`endif
                        end
                    end
                end else if (m_waiting) begin
                    m_lo_run++;
                    if (m_lo_run == DCLICK + 1) begin
                        emit      = 1'b1;
                        code      = 2'b01;
                        m_waiting = 1'b0;
                    end
                end
            end
            hs = m_valid && ev_ready;
            if (emit) begin
                if (!m_valid || hs) begin
                    m_valid = 1'b1;
                    exp_q.push_back('{code, cyc});
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on every handshake.
    logic       mon_prev_valid = 1'b0;
    logic       mon_prev_hs    = 1'b0;
    int         cur_start      = 0;
    logic [1:0] cur_code       = 2'b00;

    always @(negedge clk) begin
        logic hs;
        exp_t e;
        if (last_rst) begin
            chk("reset_outputs", {29'd0, ev_valid, ev_code, ev_ovf}, 32'd0);
            mon_prev_valid = 1'b0;
            mon_prev_hs    = 1'b0;
        end else begin
            if (mon_prev_valid && !mon_prev_hs) begin
                chk("held_stable", {29'd0, ev_valid, ev_code}, {29'd0, 1'b1, cur_code});
            end else if (ev_valid) begin
                cur_start = cyc;
                cur_code  = ev_code;
            end
            chk("ovf_flag", 32'(ev_ovf), 32'(m_ovf));
            hs = ev_valid && ev_ready && !rst;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(ev_code), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_code", 32'(ev_code), 32'(e.code));
                    chk("event_cycle", 32'(cur_start), 32'(e.cyc));
                end
            end
            mon_prev_valid = ev_valid;
            mon_prev_hs    = hs;
        end
    end

    task automatic step(input logic k, input logic r, input logic rs);
        @(posedge clk);
        #1;
        key      = k;
        ev_ready = r;
        rst      = rs;
    endtask

    task automatic drive(input logic k, input logic r, input int n);
        for (int i = 0; i < n; i++) step(k, r, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        key      = 1'b0;
        ev_ready = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 5);

        // single click
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 60);
        // double click
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 60);
        // long press, release gives nothing more
        drive(1'b1, 1'b1, 150);
        drive(1'b0, 1'b1, 60);

        // long press then click with the consumer stalled
        drive(1'b1, 1'b0, 120);
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 5);
        drive(1'b0, 1'b0, 60);
        @(negedge clk);
        chk("stall_valid", 32'(ev_valid), 32'd1);
        chk("stall_code", 32'(ev_code), 32'd3);
        chk("stall_ovf", 32'(ev_ovf), 32'd1);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        @(negedge clk);
        chk("drain_valid", 32'(ev_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(ev_ovf), 32'd1);
        drive(1'b0, 1'b1, 10);

        // second press rising on the gap terminal cycle, and one cycle later
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 40);
        drive(1'b1, 1'b1, 5);
        drive(1'b0, 1'b1, 60);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 41);
        drive(1'b1, 1'b1, 5);
        drive(1'b0, 1'b1, 60);

        // reset in the middle of a long press, key kept high
        drive(1'b1, 1'b1, 49);
        step(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1);
        @(negedge clk);
        chk("rst_mid_press", {29'd0, ev_valid, ev_code, ev_ovf}, 32'd0);
        drive(1'b1, 1'b1, 119);
        drive(1'b0, 1'b1, 60);

        for (int s = 0; s < 70; s++) begin
            int   hi;
            int   lo;
            int   mode;
            logic busy;
            mode = int'($urandom_range(0, 2));
            hi = (mode == 0) ? int'($urandom_range(1, 15)) :
                 (mode == 1) ? int'($urandom_range(96, 104)) : int'($urandom_range(1, 160));
            mode = int'($urandom_range(0, 2));
            lo = (mode == 0) ? int'($urandom_range(1, 10)) :
                 (mode == 1) ? int'($urandom_range(38, 43)) : int'($urandom_range(44, 80));
            busy = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < hi; i++) step(1'b1, busy ? ($urandom_range(0, 3) == 0) : 1'b1, 1'b0);
            for (int i = 0; i < lo; i++) step(1'b0, busy ? ($urandom_range(0, 3) == 0) : 1'b1, 1'b0);
            if ($urandom_range(0, 19) == 0) step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        drive(1'b0, 1'b1, 100);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
